// File: rtl/imm_pkg.sv
// Shared definitions for the immediate encoder: format codes (aligned with the
// decode-side ImmSrc encoding), opcode constants and the encoder FSM states.
package imm_pkg;

    typedef enum logic [2:0] {
        FMT_I  = 3'b000,
        FMT_S  = 3'b001,
        FMT_B  = 3'b010,
        FMT_J  = 3'b011,
        FMT_U  = 3'b100,
        FMT_LI = 3'b101
    } fmt_e;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_LI2  = 1'b1
    } enc_state_e;

    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;

    // True when v is representable as a signed value of the given bit width.
    function automatic logic fits_signed(input logic [31:0] v, input int unsigned bits);
        logic signed [31:0] sv;
        sv = $signed(v) >>> (bits - 1);
        return (sv == '0) || (sv == '1);
    endfunction

endpackage

// File: rtl/imm_enc_if.sv
// Request/response bundle between the boot sequencer (master) and the
// immediate encoder (slave).
interface imm_enc_if;

    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_fmt;
    logic [31:0] in_imm;
    logic [31:0] in_base;
    logic [4:0]  in_rd;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic        out_err;
    logic        out_last;

    modport master (
        output in_valid, in_fmt, in_imm, in_base, in_rd, out_ready,
        input  in_ready, out_valid, out_instr, out_err, out_last
    );

    modport slave (
        input  in_valid, in_fmt, in_imm, in_base, in_rd, out_ready,
        output in_ready, out_valid, out_instr, out_err, out_last
    );

endinterface

// File: rtl/imm_pack.sv
// Combinational packer: overwrites the immediate fields of a template word
// and flags out-of-range / misaligned immediates and illegal formats.
module imm_pack
    import imm_pkg::*;
(
    input  logic [2:0]  fmt_i,
    input  logic [31:0] imm_i,
    input  logic [31:0] base_i,
    output logic [31:0] instr_o,
    output logic        err_o
);

    always_comb begin
        instr_o = base_i;
        err_o   = 1'b1;
        case (fmt_i)
            FMT_I: begin
                instr_o = {imm_i[11:0], base_i[19:0]};
                err_o   = !fits_signed(imm_i, 12);
            end
            FMT_S: begin
                instr_o = {imm_i[11:5], base_i[24:12], imm_i[4:0], base_i[6:0]};
                err_o   = !fits_signed(imm_i, 12);
            end
            FMT_B: begin
                instr_o = {imm_i[12], imm_i[10:5], base_i[24:12],
                           imm_i[4:1], imm_i[11], base_i[6:0]};
                err_o   = !fits_signed(imm_i, 13) || imm_i[0];
            end
            FMT_J: begin
                instr_o = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], base_i[11:0]};
                err_o   = !fits_signed(imm_i, 21) || imm_i[0];
            end
            FMT_U: begin
                instr_o = {imm_i[31:12], base_i[11:0]};
                err_o   = |imm_i[11:0];
            end
            default: begin
                instr_o = base_i;
                err_o   = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/imm_enc.sv
// RV32I immediate encoder with registered single-entry output; expands the LI
// pseudo-op into LUI+ADDI across two output handshakes.
module imm_enc
    import imm_pkg::*;
#(
    parameter int unsigned CHECK_EN = 1,
    parameter int unsigned XLEN     = 32
) (
    input logic        clk,
    input logic        rst_n,
    imm_enc_if.slave   bus
);

    enc_state_e      state_q, state_d;
    logic            valid_q, valid_d;
    logic [XLEN-1:0] instr_q, instr_d;
    logic            err_q, err_d;
    logic            last_q, last_d;
    logic [XLEN-1:0] addi_q, addi_d;
    logic            addi_err_q, addi_err_d;

    logic [31:0] li_sum;
    logic [19:0] li_hi;
    logic [11:0] li_lo;
    logic [31:0] li_lo_sx;
    logic        is_li, li_split;
    logic [2:0]  p_fmt;
    logic [31:0] p_imm, p_base, p_instr, a_instr;
    logic        p_err, a_err;
    logic        in_ready_w, accept, fire;

    assign li_sum   = bus.in_imm + 32'h0000_0800;
    assign li_hi    = li_sum[31:12];
    assign li_lo    = bus.in_imm[11:0];
    assign li_lo_sx = {{20{li_lo[11]}}, li_lo};
    assign is_li    = (bus.in_fmt == FMT_LI);
    assign li_split = is_li && (li_hi != '0) && (li_lo != '0);

    // LI reuses the packer: the first word is ADDI rd,x0,lo when hi is zero,
    // otherwise LUI rd,hi; the second packer always builds ADDI rd,rd,lo.
    always_comb begin
        p_fmt  = bus.in_fmt;
        p_imm  = bus.in_imm;
        p_base = bus.in_base;
        if (is_li) begin
            if (li_hi == '0) begin
                p_fmt  = FMT_I;
                p_imm  = li_lo_sx;
                p_base = {12'b0, 5'd0, 3'b000, bus.in_rd, OPC_OPIMM};
            end else begin
                p_fmt  = FMT_U;
                p_imm  = {li_hi, 12'b0};
                p_base = {20'b0, bus.in_rd, OPC_LUI};
            end
        end
    end

    imm_pack u_pack_main (
        .fmt_i   (p_fmt),
        .imm_i   (p_imm),
        .base_i  (p_base),
        .instr_o (p_instr),
        .err_o   (p_err)
    );

    imm_pack u_pack_addi (
        .fmt_i   (FMT_I),
        .imm_i   (li_lo_sx),
        .base_i  ({12'b0, bus.in_rd, 3'b000, bus.in_rd, OPC_OPIMM}),
        .instr_o (a_instr),
        .err_o   (a_err)
    );

    assign in_ready_w = rst_n && (state_q == ST_IDLE) && (!valid_q || bus.out_ready);
    assign accept     = bus.in_valid && in_ready_w;
    assign fire       = valid_q && bus.out_ready;

    always_comb begin
        state_d    = state_q;
        valid_d    = valid_q;
        instr_d    = instr_q;
        err_d      = err_q;
        last_d     = last_q;
        addi_d     = addi_q;
        addi_err_d = addi_err_q;
        case (state_q)
            ST_LI2: begin
                if (fire) begin
                    instr_d = addi_q;
                    err_d   = addi_err_q;
                    last_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                if (accept) begin
                    valid_d    = 1'b1;
                    instr_d    = p_instr;
                    err_d      = (CHECK_EN != 0) && !is_li && p_err;
                    last_d     = !li_split;
                    addi_d     = a_instr;
                    addi_err_d = (CHECK_EN != 0) && a_err;
                    if (li_split) state_d = ST_LI2;
                end else if (fire) begin
                    valid_d = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            valid_q    <= 1'b0;
            instr_q    <= '0;
            err_q      <= 1'b0;
            last_q     <= 1'b0;
            addi_q     <= '0;
            addi_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            valid_q    <= valid_d;
            instr_q    <= instr_d;
            err_q      <= err_d;
            last_q     <= last_d;
            addi_q     <= addi_d;
            addi_err_q <= addi_err_d;
        end
    end

    assign bus.in_ready  = in_ready_w;
    assign bus.out_valid = valid_q;
    assign bus.out_instr = instr_q;
    assign bus.out_err   = err_q;
    assign bus.out_last  = last_q;

endmodule

// File: doc/imm_enc.md
Name: imm_enc

Overview:
- Instruction-word immediate encoder: the inverse of the decode-side immediate extension.
- Takes a 32-bit immediate, a format code and an instruction template. Emits a fully packed RV32I instruction word with range/alignment checking.
- Also expands the LI pseudo-op into LUI+ADDI, emitted over two handshakes.
- Sits between the self-test/boot sequencer and instruction memory write port.

Parameters:
- CHECK_EN, 1, 1 = drive out_err on range/alignment violations; 0 = out_err tied 0.
- XLEN, 32, data width; only 32 supported.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  request valid
- in_ready  out  1  request accepted when in_valid & in_ready
- in_fmt  in  3  000 I, 001 S, 010 B, 011 J, 100 U, 101 LI, others illegal
- in_imm  in  32  immediate value (signed for I/S/B/J/LI; U: full value with [11:0] expected 0)
- in_base  in  32  template: opcode/funct/reg fields; immediate bit positions ignored (overwritten)
- in_rd  in  5  destination register for LI (ignored otherwise)
- out_valid  out  1  output word valid
- out_ready  in  1  consumer ready
- out_instr  out  32  packed instruction
- out_err  out  1  immediate out of range / misaligned / illegal fmt, qualified by out_valid
- out_last  out  1  final word of the request (0 only on LUI word of two-word LI)

Behaviour:
- Reset (async, rst_n=0): state IDLE, out_valid=0, out_instr=0, out_err=0, out_last=0. in_ready=0 while rst_n=0.
- Reset mid-LI discards the pending second word.
- Registered output, single-entry skid-free buffer.
- in_ready = (state==IDLE) & (!out_valid | out_ready).
- Latency: accept at edge N, out_valid=1 after edge N. Throughput 1/cycle for non-LI requests.
- Output hold: out_instr/out_err/out_last are stable while out_valid & !out_ready. out_valid clears on a handshake with no new accept.
- Packing (template immediate bits cleared, then OR):
  - I: instr[31:20]=imm[11:0].
  - S: [31:25]=imm[11:5], [11:7]=imm[4:0].
  - B: [31]=imm[12], [7]=imm[11], [30:25]=imm[10:5], [11:8]=imm[4:1].
  - J: [31]=imm[20], [19:12]=imm[19:12], [20]=imm[11], [30:21]=imm[10:1].
  - U: [31:12]=imm[31:12].
- Range checks (err=1, word still emitted with truncated bits):
  - I/S: imm[31:11] not all equal.
  - B: imm[31:12] not all equal, or imm[0]=1.
  - J: imm[31:20] not all equal, or imm[0]=1.
  - U: imm[11:0]!=0.
  - Illegal fmt (110/111): out_instr=in_base, err=1, last=1.
- LI (in_base ignored). Compute hi=(imm+0x800)[31:12] (wrap mod 2^32), lo=imm[11:0].
  - hi==0: single ADDI rd,x0,lo; last=1.
  - lo==0: single LUI rd,hi; last=1.
  - Else: first word LUI rd,hi (last=0); state LI2 holds ADDI rd,rd,lo.
  - LI2: in_ready=0. On the out handshake, load the ADDI word (last=1) next edge and return to IDLE.
  - LI never sets err.
- Opcodes: LUI 0110111, OP-IMM 0010011 funct3 000.

Decomposition:
- Shared package imm_pkg holds:
  - fmt codes (FMT_I..FMT_LI), shared with decode ImmSrc encoding 000..100.
  - opcode constants OPC_LUI and OPC_OPIMM.
- Sub-module imm_pack: combinational (fmt, imm, base) -> (instr, err), reused for LI words.
- The FSM and output register stay in imm_enc.

Test Plan:
- B-type: fmt=010, base=0x00208063, imm=0x10, out_ready=1 -> one cycle later out_instr=0x00208863, err=0, last=1.
- LI split: fmt=101, rd=5, imm=0x12345FFF -> words 0x123462B7 (last=0) then 0xFFF28293 (last=1); in_ready=0 between them.
- LI short forms:
  - imm=0x00000005, rd=1 -> single 0x00500093.
  - imm=0x00001000, rd=1 -> single 0x000010B7.
- Range: fmt=000, base=0x00000013, imm=2048 -> out_instr=0x80000013, err=1. Same with J-type imm=3 -> err=1.
- Backpressure: out_ready=0 for 5 cycles after accept -> out_instr held, in_ready=0. Release -> drains, next request accepted the same cycle.
- Async reset asserted while in LI2 -> out_valid=0 immediately. After release, the next request produces no stale ADDI word.
